// File: rtl/uart_rx_ctrl.sv
// UART receive controller: detects a start bit, runs the baud generator for one
// frame, samples each bit on its mid-bit strobe and reports the byte or an error.
module uart_rx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 bps_clk,
    output logic                 bps_start,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic       PAR_EN   = (PARITY_EN != 0);
    localparam logic       PAR_ODD  = (PARITY_ODD != 0);

    state_t               state;
    state_t               next_state;
    logic                 rx_meta;
    logic                 rx_sync;
    logic                 rx_prev;
    logic                 rx_fall;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_mismatch;

    logic                 shift_en;
    logic                 par_check;
    logic                 stop_done;
    logic                 valid_set;
    logic                 ferr_set;
    logic                 perr_set;
    logic                 run_next;

    // Two-flop synchroniser plus a history flop; preset high so reset looks like an idle line.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall = rx_prev & ~rx_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (rx_fall) begin
                    next_state = START;
                end
            end
            START: begin
                if (bps_clk) begin
                    next_state = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bps_clk && (bit_cnt == LAST_BIT)) begin
                    next_state = PAR_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bps_clk) begin
                    next_state = STOP;
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
                if (bps_clk) begin
                    next_state = rx_sync ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (rx_sync) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        shift_en  = (state == DATA) && bps_clk;
        par_check = PAR_EN && (state == PARITY) && bps_clk;
        stop_done = (state == STOP) && bps_clk;
        valid_set = stop_done && rx_sync && !par_mismatch;
        ferr_set  = stop_done && !rx_sync;
        perr_set  = stop_done && par_mismatch;
        run_next  = (next_state == START) || (next_state == DATA) ||
                    (next_state == PARITY) || (next_state == STOP);
    end

    // Registered strobes and bps_start: no combinational path from rx reaches an output.
    // NOTE: the shift register is reset along with everything else; it is tiny and keeps X out of parity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bps_start    <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            frame_err    <= 1'b0;
            parity_err   <= 1'b0;
            bit_cnt      <= 3'd0;
            shift_reg    <= '0;
            par_mismatch <= 1'b0;
        end else begin
            bps_start  <= run_next;
            rx_valid   <= valid_set;
            frame_err  <= ferr_set;
            parity_err <= perr_set;

            if (valid_set) begin
                rx_data <= shift_reg;
            end

            if (state == START) begin
                bit_cnt <= 3'd0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
            end

            // Bits enter from the MSB side so the first bit ends up in the LSB.
            if (shift_en) begin
                shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]};
            end

            if (state == IDLE) begin
                par_mismatch <= 1'b0;
            end else if (par_check) begin
                par_mismatch <= rx_sync ^ (^shift_reg) ^ PAR_ODD;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: 8N1 and 8E1 instances, each driven by a simple
// baud-generator model with a shortened bit period.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

    // Bit period shortened from 5208 clk; the receiver only sees the mid-bit strobe.
    localparam int DIV  = 32;
    localparam int HALF = 16;
    localparam int T_VALID = 9 * DIV + HALF;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx = 1'b1;
    logic       rx_p = 1'b1;
    logic       sel_p = 1'b0;

    logic       bps_clk, bps_start, rx_valid, frame_err, parity_err, busy;
    logic [7:0] rx_data;
    logic       p_bps_clk, p_bps_start, p_rx_valid, p_frame_err, p_parity_err, p_busy;
    logic [7:0] p_rx_data;

    int tests = 0;
    int fails = 0;

    always #10 clk = ~clk;

    uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .bps_clk(bps_clk), .bps_start(bps_start),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .parity_err(parity_err), .busy(busy)
    );

    uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
        .clk(clk), .rst_n(rst_n), .rx(rx_p), .bps_clk(p_bps_clk), .bps_start(p_bps_start),
        .rx_data(p_rx_data), .rx_valid(p_rx_valid), .frame_err(p_frame_err),
        .parity_err(p_parity_err), .busy(p_busy)
    );

    // Baud generator models: counter cleared while bps_start is low, strobe at mid-bit.
    int cnt = 0;
    int cnt_p = 0;
    always @(posedge clk) begin
        if (!bps_start) cnt <= 0;
        else cnt <= (cnt == DIV - 1) ? 0 : cnt + 1;
        if (!p_bps_start) cnt_p <= 0;
        else cnt_p <= (cnt_p == DIV - 1) ? 0 : cnt_p + 1;
    end
    assign bps_clk   = bps_start && (cnt == HALF - 1);
    assign p_bps_clk = p_bps_start && (cnt_p == HALF - 1);

    // Event monitors; sampled on the falling edge, away from the DUT's active edge.
    int         cyc = 0;
    int         v_hi = 0, fe_hi = 0, pe_hi = 0, bps_rise = 0, busy_fall = 0, last_v_cyc = 0;
    int         pv_hi = 0, pfe_hi = 0, ppe_hi = 0;
    logic       bps_q = 1'b0, busy_q = 1'b0;
    logic [7:0] v_prev = 8'h00, v_last = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        bps_q  <= bps_start;
        busy_q <= busy;
        if (bps_start && !bps_q) bps_rise <= bps_rise + 1;
        if (!busy && busy_q) busy_fall <= busy_fall + 1;
        if (rx_valid) begin
            v_hi       <= v_hi + 1;
            v_prev     <= v_last;
            v_last     <= rx_data;
            last_v_cyc <= cyc;
        end
        if (frame_err) fe_hi <= fe_hi + 1;
        if (parity_err) pe_hi <= pe_hi + 1;
        if (p_rx_valid) pv_hi <= pv_hi + 1;
        if (p_frame_err) pfe_hi <= pfe_hi + 1;
        if (p_parity_err) ppe_hi <= ppe_hi + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Called on a falling edge; holds the bit for one full bit period.
    task automatic drive_bit(input logic b);
        if (sel_p) rx_p = b;
        else rx = b;
        repeat (DIV) @(negedge clk);
    endtask

    int frame_t0 = 0;

    task automatic send_frame(input logic [7:0] d, input logic par_b, input logic stop_b);
        frame_t0 = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (sel_p) drive_bit(par_b);
        drive_bit(stop_b);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    int b_v, b_fe, b_pe, b_rise, b_fall, b_pv, b_pfe, b_ppe, dt;

    initial begin
        rst_n = 1'b1;
        #5;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bps_start", bps_start, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_parity_err", parity_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        b_pe = pe_hi;

        // 8N1 0x55: one valid pulse at ~9.5 bit times
        b_v = v_hi; b_fe = fe_hi;
        send_frame(8'h55, 1'b0, 1'b1);
        repeat (4) settle();
        dt = last_v_cyc - frame_t0;
        check("55_valid_cycles", v_hi - b_v, 1);
        check("55_rx_data", rx_data, 8'h55);
        check("55_frame_err", fe_hi - b_fe, 0);
        check("55_bps_start_low", bps_start, 1'b0);
        check("55_valid_timing", (dt >= T_VALID - 3) && (dt <= T_VALID + 3), 1'b1);

        // Short low glitch: generator starts then stops at the first strobe
        b_v = v_hi; b_fe = fe_hi; b_rise = bps_rise;
        @(negedge clk);
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("glitch_bps_start_high", bps_start, 1'b1);
        check("glitch_busy_high", busy, 1'b1);
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (40) settle();
        check("glitch_bps_start_low", bps_start, 1'b0);
        check("glitch_busy_low", busy, 1'b0);
        check("glitch_no_valid", v_hi - b_v, 0);
        check("glitch_no_ferr", fe_hi - b_fe, 0);
        check("glitch_one_start", bps_rise - b_rise, 1);

        // Back-to-back 0xA3, 0x0F with no idle gap
        b_v = v_hi; b_fall = busy_fall;
        @(negedge clk);
        send_frame(8'hA3, 1'b0, 1'b1);
        send_frame(8'h0F, 1'b0, 1'b1);
        repeat (4) settle();
        check("b2b_valid_count", v_hi - b_v, 2);
        check("b2b_first_data", v_prev, 8'hA3);
        check("b2b_second_data", v_last, 8'h0F);
        check("b2b_busy_gap", busy_fall - b_fall, 2);

        // 0x3C with low stop bit, line held low 3 bits, then 0x81
        b_v = v_hi; b_fe = fe_hi; b_rise = bps_rise;
        @(negedge clk);
        send_frame(8'h3C, 1'b0, 1'b0);
        drive_bit(1'b0);
        settle();
        check("brk_busy_held", busy, 1'b1);
        check("brk_bps_start_low", bps_start, 1'b0);
        @(negedge clk);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        settle();
        check("brk_frame_err", fe_hi - b_fe, 1);
        check("brk_no_valid", v_hi - b_v, 0);
        check("brk_rx_data_kept", rx_data, 8'h0F);
        check("brk_no_retrigger", bps_rise - b_rise, 1);
        check("brk_busy_released", busy, 1'b0);
        @(negedge clk);
        send_frame(8'h81, 1'b0, 1'b1);
        repeat (4) settle();
        check("after_brk_valid", v_hi - b_v, 1);
        check("after_brk_data", rx_data, 8'h81);

        // 8E1 instance: good parity, bad parity on 0x07, bad parity on 0x05
        sel_p = 1'b1;
        b_pv = pv_hi; b_pfe = pfe_hi; b_ppe = ppe_hi;
        @(negedge clk);
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (4) settle();
        check("par_good_valid", pv_hi - b_pv, 1);
        check("par_good_data", p_rx_data, 8'h07);
        check("par_good_no_perr", ppe_hi - b_ppe, 0);
        @(negedge clk);
        send_frame(8'h07, 1'b0, 1'b1);
        repeat (4) settle();
        check("par_bad07_perr", ppe_hi - b_ppe, 1);
        check("par_bad07_no_valid", pv_hi - b_pv, 1);
        @(negedge clk);
        send_frame(8'h05, 1'b1, 1'b1);
        repeat (4) settle();
        check("par_bad05_perr", ppe_hi - b_ppe, 2);
        check("par_bad05_data_kept", p_rx_data, 8'h07);
        check("par_no_ferr", pfe_hi - b_pfe, 0);
        sel_p = 1'b0;

        // Reset asserted during data bit 4 of 0x5A
        @(negedge clk);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rx = 1'b1;
        repeat (HALF) @(negedge clk);
        check("mid_busy_before_rst", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_bps_start", bps_start, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_rx_data", rx_data, 8'h00);
        check("mid_rst_strobes", {rx_valid, frame_err, parity_err}, 3'b000);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (DIV) @(negedge clk);
        b_v = v_hi;
        send_frame(8'hC6, 1'b0, 1'b1);
        repeat (4) settle();
        check("post_rst_valid", v_hi - b_v, 1);
        check("post_rst_data", rx_data, 8'hC6);
        check("no_parity_err_8n1", pe_hi - b_pe, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- UART receive controller; the consumer of the baud-rate generator's mid-bit strobe.
- Detects a start bit on the asynchronous serial line and holds bps_start high to run the generator for one frame.
- Samples each bit on the generator's bps_clk pulse, then presents a received byte with a one-cycle valid strobe, or flags a framing/parity error.
- Sits between the board RX pin and the byte-level command/FIFO logic.

Parameters:
- DATA_BITS, 8: data bits per frame, range 5..8, sent LSB first.
- PARITY_EN, 0: 1 = a parity bit follows the data bits.
- PARITY_ODD, 0: with PARITY_EN=1, 1 = odd parity, 0 = even parity.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous reset, active-low.
- rx  input  1  serial line; asynchronous; idle high.
- bps_clk  input  1  one-cycle mid-bit strobe from the baud generator.
- bps_start  output  1  high while a frame is being received; enables the baud generator.
- rx_data  output  DATA_BITS  last good byte received; zero-extended order, LSB = first bit.
- rx_valid  output  1  one-cycle pulse: rx_data has just been updated.
- frame_err  output  1  one-cycle pulse: stop bit was sampled low.
- parity_err  output  1  one-cycle pulse: parity mismatch (always 0 when PARITY_EN=0).
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: rst_n is asynchronous, active-low; the clock is clk. While reset is asserted:
  - all outputs are 0; rx_data = 0.
  - the synchroniser flops are preset to 1 (line idle).
  - the state machine goes to IDLE and the bit counter to 0.
- Synchroniser:
  - rx passes through 2 flops; a third flop holds the previous synchronised value.
  - fall = previous & ~current.
  - Detection latency is 3 clk cycles from the rx edge.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE:
  - On fall: go to START and set bps_start=1 on the next cycle.
  - With no fall, the state is held.
- START: on the first bps_clk, sample the synchronised rx.
  - If 0: go to DATA and clear the bit counter.
  - If 1 (glitch): go to IDLE and set bps_start=0. No output strobe.
- DATA:
  - Each bps_clk shifts the sampled bit into a shift register from the MSB side, so the first bit lands in the LSB after DATA_BITS shifts.
  - On the DATA_BITS-th pulse, go to PARITY if PARITY_EN, otherwise go to STOP.
- PARITY:
  - On bps_clk, compare the sampled bit with the XOR of the data bits; invert the XOR when PARITY_ODD.
  - Latch a mismatch flag, then go to STOP.
- STOP: on bps_clk, sample the stop bit. The next cycle:
  - Stop=1 and no parity mismatch: rx_data <= shift register and rx_valid=1 for exactly 1 cycle. Go to IDLE.
  - Stop=1 with a parity mismatch: parity_err=1 for 1 cycle, rx_data unchanged. Go to IDLE.
  - Stop=0: frame_err=1 for 1 cycle, rx_data unchanged. parity_err is also pulsed if there was a mismatch. Go to WAIT_HIGH.
  - In every case bps_start=0 from this cycle on.
- WAIT_HIGH:
  - bps_start=0 and busy=1.
  - Stay until the synchronised rx=1, then go to IDLE. This stops a held-low line (break) from re-triggering.
- Output rules:
  - bps_clk outside START/DATA/PARITY/STOP is ignored.
  - bps_start is registered and has no combinational path from rx.
- Back-to-back frames:
  - Leaving STOP for IDLE at mid-stop-bit gives at least half a bit of margin.
  - A start edge that arrives right after stop must be detected.
  - busy drops for at least 1 cycle between frames.
- Strobes are mutually exclusive per frame, except frame_err+parity_err.
- Reset mid-frame: outputs go to 0 immediately and bps_start drops.
  - After reset, the next frame is received correctly only if its start edge comes after rst_n is released.

Test Plan:
- Bench setup: DUT connected to the 50 MHz baud generator (divisor 5208, strobe at count 2604); rx driven at 5208 clk per bit.
- Send 8N1 0x55 -> exactly one rx_valid pulse; rx_data=0x55; the pulse falls about 9.5 bit times after the start edge (±3 clk); bps_start low afterwards; frame_err=0.
- rx low for 1000 clk, then high -> bps_start rises, drops after the first bps_clk; no strobes; state returns to IDLE.
- Send 0xA3, then 0x0F with zero idle gap -> two rx_valid pulses, data 0xA3 then 0x0F; busy low for at least 1 cycle between the frames.
- Send 0x3C with the stop bit low, keep rx low 3 bit times, then send 0x81 -> frame_err 1 pulse; rx_data stays at the previous value; no re-trigger while low; then rx_valid with 0x81.
- PARITY_EN=1, PARITY_ODD=0: send 0x07 with parity 1 -> rx_valid; send 0x07 with parity 0 -> parity_err pulse; rx_data unchanged.
- Assert rst_n low during bit 4 of a frame -> all outputs 0 at once; the next clean frame 0xC6 is received correctly.
